// File: rtl/ctrl_trace_encoder.sv
// ctrl_trace_encoder: turns the LEGLite control bundle back into its 3-bit opcode.
// Each sampled instruction becomes a {match, opcode, stamp} entry. Entries are
// queued in a first-word-fall-through FIFO and drained over a valid/ready port.
// Optional feature macro: CTRL_TRACE_STAMP_EN. When it is defined, a 12-bit
// free-running cycle stamp is recorded in out_data[11:0]. When it is undefined,
// those bits are always zero.
module ctrl_trace_encoder #(
  parameter int DEPTH = 8,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          sample,
  input  logic          reg2loc,
  input  logic          branch,
  input  logic          memread,
  input  logic          memtoreg,
  input  logic          memwrite,
  input  logic          alusrc,
  input  logic          regwrite,
  input  logic [2:0]    alu_select,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   out_data,
  output logic [LW-1:0] level,
  output logic [7:0]    overflow_cnt,
  output logic [7:0]    bad_cnt
);

  localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [9:0]    bundle;
  logic          match;
  logic [2:0]    opcode;
  logic [11:0]   stamp;
  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  assign bundle = {reg2loc, branch, memread, memtoreg, alu_select,
                   memwrite, alusrc, regwrite};

  // Inverse decode: map a legal control bundle back to its opcode.
  always_comb begin
    match  = 1'b1;
    opcode = 3'd0;
    case (bundle)
      10'b0000000001: opcode = 3'd0;
      10'b1000001001: opcode = 3'd1;
      10'b1000010001: opcode = 3'd2;
      10'b0011000011: opcode = 3'd3;
      10'b1000000110: opcode = 3'd4;
      10'b1100010000: opcode = 3'd5;
      10'b0000000011: opcode = 3'd6;
      10'b1000100011: opcode = 3'd7;
      default: begin
        match  = 1'b0;
        opcode = 3'd0;
      end
    endcase
  end

`ifdef CTRL_TRACE_STAMP_EN
  // Free-running cycle stamp; wraps naturally at 4096.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) stamp <= '0;
    else        stamp <= stamp + 12'd1;
  end
`else
  assign stamp = '0;
`endif

  // A pop frees a slot on the same edge, so a full FIFO can still accept a push.
  assign full = (count == DEPTH_L);
  assign pop  = (count != '0) && out_ready;
  assign push = sample && (!full || pop);
  assign drop = sample && full && !pop;

  // Entry storage. It is not reset because the count gates visibility.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {match, opcode, stamp};
  end

  // Pointers, occupancy and saturating event counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_cnt <= '0;
      bad_cnt      <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + LW'(1);
      else if (pop && !push) count <= count - LW'(1);
      if (drop && overflow_cnt != 8'hFF)       overflow_cnt <= overflow_cnt + 8'd1;
      if (sample && !match && bad_cnt != 8'hFF) bad_cnt     <= bad_cnt + 8'd1;
    end
  end

  // Head presentation depends only on registered state, never on out_ready.
  always_comb begin
    out_valid = (count != '0);
    out_data  = out_valid ? mem[rd_ptr] : 16'h0000;
  end

  assign level = count;

endmodule

// File: tb/tb_ctrl_trace_encoder.sv
// Scoreboard bench for ctrl_trace_encoder. The driver works after each rising
// edge. The monitor works on the falling edge: it checks the outputs against the
// reference queue and then advances that queue for the coming edge.
`timescale 1ns/1ps
module tb_ctrl_trace_encoder;

  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          sample = 1'b0;
  logic          out_ready = 1'b0;
  logic [9:0]    b = '0;
  logic          out_valid;
  logic [15:0]   out_data;
  logic [LW-1:0] level;
  logic [7:0]    overflow_cnt, bad_cnt;

  ctrl_trace_encoder #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .sample(sample),
    .reg2loc(b[9]), .branch(b[8]), .memread(b[7]), .memtoreg(b[6]),
    .alu_select(b[5:3]), .memwrite(b[2]), .alusrc(b[1]), .regwrite(b[0]),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .overflow_cnt(overflow_cnt), .bad_cnt(bad_cnt));

  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model state.
  logic [15:0] q[$];
  int m_ovf   = 0;
  int m_bad   = 0;
  int m_stamp = 0;
  logic [9:0] table_b [8] = '{10'b0000000001, 10'b1000001001, 10'b1000010001,
                              10'b0011000011, 10'b1000000110, 10'b1100010000,
                              10'b0000000011, 10'b1000100011};

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_entry(input logic [9:0] bun, input int st);
    int op = -1;
    for (int i = 0; i < 8; i++) if (table_b[i] == bun) op = i;
`ifdef CTRL_TRACE_STAMP_EN
    st = st % 4096;
`else
    st = 0;
`endif
    if (op < 0) return {1'b0, 3'd0, 12'd0};
    return {1'b1, 3'(op), 12'(st)};
  endfunction

  // Monitor: compare the DUT against the queue, then apply this cycle's edge.
  always @(negedge clock) begin
    if (!reset) begin
      q.delete();
      m_ovf = 0; m_bad = 0; m_stamp = 0;
    end else begin
      bit full, pop;
      logic [15:0] e;
      chk("out_valid", int'(out_valid), int'(q.size() != 0));
      chk("out_data", int'(out_data), (q.size() != 0) ? int'(q[0]) : 0);
      chk("level", int'(level), q.size());
      chk("overflow_cnt", int'(overflow_cnt), m_ovf);
      chk("bad_cnt", int'(bad_cnt), m_bad);
      full = (q.size() == DEPTH);
      pop  = (q.size() != 0) && out_ready;
      if (pop) void'(q.pop_front());
      if (sample) begin
        e = ref_entry(b, m_stamp);
        if (!e[15] && m_bad < 255) m_bad++;
        if (!full || pop) q.push_back(e);
        else if (m_ovf < 255) m_ovf++;
      end
      m_stamp = (m_stamp + 1) % 4096;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic idle();
    sample = 1'b0; b = '0; out_ready = 1'b0;
  endtask

  task automatic drain();
    idle();
    out_ready = 1'b1;
    step(DEPTH + 2);
    out_ready = 1'b0;
  endtask

  initial begin
    step(3);
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_data", int'(out_data), 0);
    reset = 1'b1;
    step(1);

    // The eight table bundles back to back, starting at stamp 10.
    while (m_stamp != 10) step(1);
    for (int i = 0; i < 8; i++) begin
      sample = 1'b1; b = table_b[i];
      step(1);
    end
    idle();
    chk("fill_level", int'(level), 8);
    chk("table_bad", int'(bad_cnt), 0);
`ifdef CTRL_TRACE_STAMP_EN
    chk("head_stamp", int'(out_data), 16'h800A);
`else
    chk("head_nostamp", int'(out_data), 16'h8000);
`endif
    drain();
    chk("drain_level", int'(level), 0);

    // Unmatched bundles.
    sample = 1'b1; b = 10'h000; step(1);
    b = 10'h3FF; step(1);
    idle();
    chk("bad_two", int'(bad_cnt), 2);
    chk("bad_entry", int'(out_data), 0);
    drain();

    // Overflow, then push and pop on the same edge while full.
    for (int i = 0; i < 11; i++) begin
      sample = 1'b1; b = table_b[i % 8];
      step(1);
    end
    idle();
    chk("ovf_three", int'(overflow_cnt), 3);
    chk("ovf_level", int'(level), 8);
    chk("ovf_head_op", int'(out_data[14:12]), 0);
    sample = 1'b1; b = table_b[5]; out_ready = 1'b1;
    step(1);
    idle();
    chk("fullpp_level", int'(level), 8);
    chk("fullpp_head_op", int'(out_data[14:12]), 1);
    drain();

    // Reset while five entries are queued.
    for (int i = 0; i < 5; i++) begin
      sample = 1'b1; b = table_b[i];
      step(1);
    end
    idle();
    reset = 1'b0;
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_ovf", int'(overflow_cnt), 0);
    chk("rst_bad", int'(bad_cnt), 0);
    step(1);
    reset = 1'b1;
    sample = 1'b1; b = table_b[6];
    step(1);
    idle();
    chk("post_rst_level", int'(level), 1);
    chk("post_rst_op", int'(out_data[15:12]), 4'hE);
`ifndef CTRL_TRACE_STAMP_EN
    chk("addi_nostamp", int'(out_data), 16'hE000);
`endif
    drain();

    // Random traffic with ready-probability phases, so that both
    // overflow and bad_cnt saturation are reached.
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 800; c++) begin
        sample = ($urandom_range(0, 1) == 1);
        b = ($urandom_range(0, 1) == 1) ? table_b[$urandom_range(0, 7)]
                                        : 10'($urandom_range(0, 1023));
        case (ph)
          0: out_ready = ($urandom_range(0, 3) == 0);
          1: out_ready = ($urandom_range(0, 1) == 0);
          2: out_ready = ($urandom_range(0, 9) == 0);
          default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
        step(1);
      end
    end
    drain();
    chk("end_ovf_sat", int'(overflow_cnt), m_ovf);
    chk("end_bad_sat", int'(bad_cnt), 255);
    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_trace_encoder.md
# ctrl_trace_encoder

Re-encodes the control-signal bundle driven into the LEGLite datapath back into its 3-bit opcode. Each sampled instruction is stamped, queued in a small FIFO, and drained through a valid/ready port. The block sits beside the single-cycle datapath as a non-intrusive debug/trace monitor: the inverse of the opcode-to-control decode.

## Interface
- DEPTH, 8, FIFO entries; power of two, 2..16
- LW, $clog2(DEPTH)+1, width of `level`
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- sample  in  1  high for one cycle per executed instruction; bundle valid this cycle
- reg2loc, branch, memread, memtoreg, memwrite, alusrc, regwrite  in  1 each  control bits as driven to datapath
- alu_select  in  3  ALU select as driven to datapath
- out_valid  out  1  head entry present
- out_ready  in  1  consumer accepts head entry
- out_data  out  16  head entry: [15] match, [14:12] opcode, [11:0] stamp
- level  out  LW  entries currently held
- overflow_cnt  out  8  dropped samples, saturating
- bad_cnt  out  8  samples with no matching bundle, saturating

## Operation
- The bundle is B = {reg2loc, branch, memread, memtoreg, alu_select[2:0], memwrite, alusrc, regwrite} (10 bits, MSB first).
- Encode table (B -> opcode):
  - 0000000001 -> 0 (ADD)
  - 1000001001 -> 1 (SUB)
  - 1000010001 -> 2 (PASS)
  - 0011000011 -> 3 (LD)
  - 1000000110 -> 4 (ST)
  - 1100010000 -> 5 (CBZ)
  - 0000000011 -> 6 (ADDI)
  - 1000100011 -> 7 (ANDI)
- Matching bundle: match=1, with the opcode from the table.
- Any other bundle, including all-zero (the idle/default bundle): match=0, opcode=0, and bad_cnt increments (saturating at 255).
- Encoding is combinational; the entry is written on the clock edge where sample=1.
- stamp is a 12-bit free-running cycle counter. It increments every cycle, wraps from 4095 to 0, and records its value at the sample edge.
- FIFO is first-word-fall-through:
  - out_valid = (level != 0).
  - out_data is the head entry, or 0 when empty.
- Pop: out_valid && out_ready at a rising edge.
- Push: sample at a rising edge, and either not full or a pop occurs in the same edge.
- Full without a pop: the sample is dropped and overflow_cnt increments (saturating). The FIFO contents are unchanged, and bad_cnt still counts an unmatched dropped sample.
- Full with simultaneous pop: both the pop and the push occur, and level stays at DEPTH.
- Empty with out_ready: no effect.
- Pointers wrap modulo DEPTH.

## Timing
- Reset (asynchronous assert, synchronous release) clears everything: out_valid=0, out_data=0, level=0, overflow_cnt=0, bad_cnt=0, stamp=0, pointers=0.
- Reset mid-operation discards all queued entries immediately.
- Latency when empty: a sample at edge k gives out_valid=1 and a valid out_data in the cycle after edge k.
- level updates at the same edge as the push/pop: +1, -1, or 0.
- out_data must stay stable while out_valid=1 and out_ready=0.
- No combinational path from out_ready to out_valid or out_data.

## Configuration
- CTRL_TRACE_STAMP_EN defined: the stamp counter is present, and out_data[11:0] carries the stamp.
- CTRL_TRACE_STAMP_EN undefined: no counter is built, and out_data[11:0] is always 0.
- All other behaviour is identical in both builds.

## Test plan
- Eight samples in consecutive cycles, one per table bundle, out_ready=0, starting at stamp 10 (macro defined). Then drain with out_ready=1. Required: opcodes 0..7 in order, match=1, stamps 10..17, level 8 then 0, bad_cnt=0.
- Bundle 0000000000 and bundle 1111111111 sampled. Required: two entries with match=0 and opcode=0, bad_cnt=2.
- Fill to 8 with out_ready=0, then three more samples. Required: overflow_cnt=3, level=8, and the head is still the first sample.
- Full FIFO, with sample and out_ready both high for one edge. Required: level stays 8, the old head is popped, and the new entry is at the tail.
- Push 5 entries and assert reset for one cycle mid-stream. Required: all outputs are 0 immediately; after release, a new sample appears as the sole entry.
- With the macro undefined, an ADDI sample. Required: out_data = 0xE000.
